// File: rtl/ksa_operand_sequencer_if.sv
// Wishbone slave bus bundle for the Kogge-Stone adder sequencer.
// The master modport drives requests; the slave modport returns ack/data.
interface ksa_operand_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ksa_operand_sequencer.sv
// Wishbone feeder/capture stage for a 16-bit Kogge-Stone adder.
// Optional accumulate mode and sticky overflow: define KSA_ACCUM_EN.
module ksa_operand_sequencer #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    ksa_operand_sequencer_if.slave        wbs,
    output logic [15:0]                   op_a,
    output logic [15:0]                   op_b,
    input  logic [15:0]                   sum_i,
    input  logic                          cout_i,
    output logic                          irq_o
);
    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, CAPTURE, DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [16:0] result;
    logic        done;
    logic        busy;
    logic        capture;
    logic        load_cnt;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic [31:0] stat;
    logic        access;
    logic        wr;
    logic [1:0]  rsel;
    logic        ctrl_wr;
    logic        start_go;
    logic        clr_req;
    logic        unused_bits;

    assign access = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q
                  & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr       = access & wbs.wbs_we_i;
    assign rsel     = wbs.wbs_adr_i[3:2];
    assign ctrl_wr  = wr & (rsel == 2'd2) & wbs.wbs_sel_i[0];
    assign busy     = (state == LOAD) | (state == SETTLE)
                    | (state == CAPTURE);
    assign start_go = ctrl_wr & wbs.wbs_dat_i[0] & ~busy;
    assign clr_req  = ctrl_wr & wbs.wbs_dat_i[1];
    assign irq_o    = done;

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    assign unused_bits = ^{wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:16],
                           wbs.wbs_adr_i[1:0]};

`ifdef KSA_ACCUM_EN
    logic acc_mode;
    logic ovf;

    // Accumulate-mode bit and sticky overflow flag
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            acc_mode <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (ctrl_wr)
                acc_mode <= wbs.wbs_dat_i[2];
            if (capture)
                ovf <= ovf | cout_i;
            else if (clr_req)
                ovf <= 1'b0;
        end
    end

    assign stat = {28'b0, ovf, acc_mode, done, busy};
`else
    assign stat = {30'b0, done, busy};
`endif

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state and per-state strobes
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        load_cnt = 1'b0;
        unique case (state)
            IDLE:    if (start_go) state_nx = LOAD;
            LOAD: begin
                load_cnt = 1'b1;
                state_nx = SETTLE;
            end
            SETTLE:  if (cnt == 4'd1) state_nx = CAPTURE;
            CAPTURE: begin
                capture  = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = start_go ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Settle counter: loaded in LOAD, counts down through SETTLE
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            cnt <= 4'd0;
        else if (load_cnt)
            cnt <= SETTLE_INIT;
        else if (state == SETTLE)
            cnt <= cnt - 4'd1;
    end

    // Operand registers; bus writes are dropped while busy
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            op_a <= 16'h0000;
            op_b <= 16'h0000;
        end else begin
`ifdef KSA_ACCUM_EN
            if (capture && acc_mode)
                op_a <= sum_i;
`endif
            if (wr && !busy && rsel == 2'd0) begin
                if (wbs.wbs_sel_i[0]) op_a[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) op_a[15:8] <= wbs.wbs_dat_i[15:8];
            end
            if (wr && !busy && rsel == 2'd1) begin
                if (wbs.wbs_sel_i[0]) op_b[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) op_b[15:8] <= wbs.wbs_dat_i[15:8];
            end
        end
    end

    // Result capture and done flag; capture beats a same-cycle clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            result <= 17'h0;
            done   <= 1'b0;
        end else begin
            if (capture)
                result <= {cout_i, sum_i};
            if (capture)
                done <= 1'b1;
            else if (start_go || clr_req)
                done <= 1'b0;
        end
    end

    // Read data mux
    always_comb begin
        rdata = 32'h0;
        unique case (rsel)
            2'd0: rdata = {16'h0, op_a};
            2'd1: rdata = {16'h0, op_b};
            2'd2: rdata = stat;
            2'd3: rdata = {15'h0, result};
            default: rdata = 32'h0;
        endcase
    end

    // Registered single-cycle ack; read data only alongside ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= access;
            dat_q <= (access && !wbs.wbs_we_i) ? rdata : 32'h0;
        end
    end
endmodule

// File: tb/tb_ksa_operand_sequencer.sv
// Scoreboard bench for ksa_operand_sequencer.
// Build with +define+KSA_ACCUM_EN to cover accumulate mode.
module tb_ksa_operand_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_OPA = BASE + 32'h0;
    localparam logic [31:0] A_OPB = BASE + 32'h4;
    localparam logic [31:0] A_CTL = BASE + 32'h8;
    localparam logic [31:0] A_RES = BASE + 32'hC;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] sum;
    logic        cout;
    logic        irq;
    int          vectors;
    int          errors;
    sb_t         sbq[$];

    ksa_operand_sequencer_if wb ();

    ksa_operand_sequencer dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs       (wb),
        .op_a      (op_a),
        .op_b      (op_b),
        .sum_i     (sum),
        .cout_i    (cout),
        .irq_o     (irq)
    );

    // External adder stand-in
    assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        if (wb.wbs_ack_o) begin
            if (sbq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (e.chk) chk(e.name, wb.wbs_dat_o, e.exp);
            end
        end else if (wb.wbs_dat_o !== 32'h0) begin
            chk("dat_idle", wb.wbs_dat_o, 32'h0);
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input string nm, input logic [31:0] exp);
        sb_t e;
        int  n;
        e.chk  = !we;
        e.exp  = exp;
        e.name = nm;
        sbq.push_back(e);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.wbs_ack_o && n < 8);
        chk({"ack_lat_", nm}, 32'(n), 32'd1);
        if (!wb.wbs_ack_o && sbq.size() != 0) void'(sbq.pop_back());
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 4'hF, "wr", 32'h0);
    endtask

    task automatic rd(input logic [31:0] adr, input string nm,
                      input logic [31:0] exp);
        bus(1'b0, adr, 32'h0, 4'hF, nm, exp);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!irq) begin
            vectors++;
            errors++;
            $display("FAIL irq_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        int n;
        int seen;
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'h0;
        wb.wbs_adr_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_op_a", 32'(op_a), 32'h0);
        chk("rst_op_b", 32'(op_b), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
        rst_n = 1'b1;
        rd(A_CTL, "rst_stat", 32'h0);
        rd(A_RES, "rst_res", 32'h0);

        // Basic add and done latency
        wr(A_OPA, 32'h1234);
        wr(A_OPB, 32'h4321);
        chk("op_a_drv", 32'(op_a), 32'h1234);
        wr(A_CTL, 32'h1);
        wait_irq(n);
        chk("done_lat", 32'(n), 32'd4);
        rd(A_RES, "res_5555", 32'h0000_5555);
        rd(A_CTL, "stat_done", 32'h2);

        // Carry out, then clear-done
        wr(A_OPA, 32'hFFFF);
        wr(A_OPB, 32'h0001);
        wr(A_CTL, 32'h1);
        wait_irq(n);
        chk("done_lat2", 32'(n), 32'd4);
        rd(A_RES, "res_carry", 32'h0001_0000);
        wr(A_CTL, 32'h2);
        chk("irq_clr", 32'(irq), 32'h0);
        rd(A_CTL, "stat_clr", 32'h0);

        // Writes and start during busy are dropped
        wr(A_OPA, 32'h0001);
        wr(A_OPB, 32'h0002);
        wr(A_CTL, 32'h1);
        wr(A_OPA, 32'hAAAA);
        wr(A_CTL, 32'h1);
        chk("busy_op_a", 32'(op_a), 32'h0001);
        wait_irq(n);
        repeat (6) @(negedge clk);
        rd(A_CTL, "one_capture", 32'h2);
        rd(A_RES, "res_3", 32'h0000_0003);

        // Start+clear together; RESULT read while busy
        wr(A_OPB, 32'h0005);
        wr(A_CTL, 32'h3);
        rd(A_CTL, "stat_start_clr", 32'h1);
        rd(A_RES, "res_prev", 32'h0000_0003);
        wait_irq(n);
        rd(A_RES, "res_6", 32'h0000_0006);

        // Clear lands on the capture cycle
        wr(A_CTL, 32'h1);
        repeat (2) @(negedge clk);
        wr(A_CTL, 32'h2);
        chk("cap_beats_clr", 32'(irq), 32'h1);
        rd(A_CTL, "stat_cap_clr", 32'h2);
`ifndef KSA_ACCUM_EN
        wr(A_CTL, 32'hC);
        rd(A_CTL, "stat_hi_zero", 32'h2);
`endif

        // Byte selects
        wr(A_OPA, 32'h0000);
        bus(1'b1, A_OPA, 32'hBEEF, 4'b0001, "wr_sel", 32'h0);
        rd(A_OPA, "opa_sel", 32'h0000_00EF);

        // Non-matching address is not acked
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_adr_i = BASE + 32'h10;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) seen = 1;
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        chk("no_ack", 32'(seen), 32'h0);

        // Reset during SETTLE aborts the operation
        wr(A_CTL, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_op_a", 32'(op_a), 32'h0);
        chk("mid_rst_op_b", 32'(op_b), 32'h0);
        rd(A_CTL, "mid_rst_stat", 32'h0);
        rd(A_RES, "mid_rst_res", 32'h0);
        repeat (8) @(negedge clk);
        chk("no_late_cap", 32'(irq), 32'h0);

`ifdef KSA_ACCUM_EN
        // Four accumulating starts wrap OPA back to zero
        wr(A_OPA, 32'h0000);
        wr(A_OPB, 32'h4000);
        wr(A_CTL, 32'h5);
        wait_irq(n);
        chk("acc_1", 32'(op_a), 32'h4000);
        for (int k = 0; k < 3; k++) begin
            wr(A_CTL, 32'h5);
            wait_irq(n);
        end
        chk("acc_wrap", 32'(op_a), 32'h0000);
        rd(A_CTL, "acc_stat", 32'hE);
        rd(A_RES, "acc_res", 32'h0001_0000);
        wr(A_CTL, 32'h6);
        rd(A_CTL, "ovf_clr", 32'h4);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule

// File: doc/ksa_operand_sequencer.md
Name: ksa_operand_sequencer

Overview:
- Wishbone-controlled feeder and capture stage for the 16-bit Kogge-Stone adder in the Caravel user area.
- Holds operands A and B in registers and drives them onto the adder inputs.
- On a start command, waits a fixed settle time, then captures {cout, sum} into a result register.
- Reports busy/done through a status register and raises an interrupt on completion.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone base address; decode compares wbs_adr_i[31:4] with BASE_ADDR[31:4].
- SETTLE_CYCLES, 2: cycles the operands are held stable before capture. Legal range 1..15.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge.
- wb_rst_ni  input  1  asynchronous, active-low reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects; sel[0] enables bits 7:0, sel[1] enables bits 15:8.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  address.
- wbs_ack_o  output  1  registered acknowledge.
- wbs_dat_o  output  32  read data.
- op_a  output  16  adder operand A.
- op_b  output  16  adder operand B.
- sum_i  input  16  adder sum.
- cout_i  input  1  adder carry-out.
- irq_o  output  1  done interrupt, level.

Behaviour:
- Reset (wb_rst_ni low, asynchronous) forces:
  - op_a = op_b = 0, result register = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0.
  - FSM to IDLE; done = 0; busy = 0.
  - Reset mid-operation aborts with no capture.
- Register map, selected by wbs_adr_i[3:2]:
  - 0 OPA: RW, bits 15:0.
  - 1 OPB: RW, bits 15:0.
  - 2 CTRL/STAT:
    - Write bit0 = start, bit1 = clear done.
    - Read bit0 = busy, bit1 = done; other bits 0.
  - 3 RESULT: RO, {15'b0, cout, sum}.
- Bus handshake:
  - Access when wbs_cyc_i & wbs_stb_i & address match & !wbs_ack_o.
  - wbs_ack_o pulses high for exactly one cycle, one cycle after the access.
  - wbs_dat_o is valid with ack and 0 otherwise.
  - No ack for non-matching addresses.
  - Writes to RESULT are acked and ignored.
- Writes to OPA/OPB while busy = 1 are acked and discarded.
- FSM:
  - IDLE: start write → LOAD; busy = 1, done = 0.
  - LOAD: settle counter = SETTLE_CYCLES; → SETTLE.
  - SETTLE: counter decrements each cycle; at 1 → CAPTURE.
  - CAPTURE: result = {cout_i, sum_i}; → DONE.
  - DONE: busy = 0, done = 1, irq_o = 1; → IDLE on the next cycle with done held.
- Timing: done rises SETTLE_CYCLES+2 cycles after the cycle the start write is accepted.
- Start while busy is ignored.
- Start while done = 1 clears done and launches a new operation.
- Clear-done write clears done and irq_o.
- Start and clear in the same write: start wins, so done = 0 and busy = 1.
- Capture and clear in the same cycle: capture wins, so done = 1.
- A RESULT read during busy returns the previous result.
- Arithmetic: 17-bit result; the carry-out is captured unmodified; no wrap handling beyond the adder.

Optional Feature:
- Macro: KSA_ACCUM_EN.
- When defined:
  - CTRL write bit2 = accumulate mode, a sticky register bit, readable at STAT bit2.
  - In accumulate mode, CAPTURE also writes sum_i into OPA, so repeated starts add OPB into a running total.
  - cout_i ORs into a sticky overflow flag at STAT bit3, cleared by clear-done.
- When undefined:
  - Bits 2 and 3 read 0 and writes to them are ignored.
  - OPA is changed only by bus writes.

Test Plan:
- Reset mid-SETTLE (wb_rst_ni low for 1 cycle) → busy = 0, done = 0, irq_o = 0, RESULT read = 0x0000_0000, op_a = op_b = 0.
- Write OPA = 0x1234, OPB = 0x4321, start → done after SETTLE_CYCLES+2 = 4 cycles, RESULT = 0x0000_5555, irq_o = 1.
- OPA = 0xFFFF, OPB = 0x0001, start → RESULT = 0x0001_0000 (cout = 1). Clear-done → irq_o = 0, done = 0.
- During busy:
  - Write OPA = 0xAAAA and issue start → both ignored; op_a unchanged.
  - Exactly one capture occurs.
  - Every access acks in one cycle.
- Byte selects: write OPA 0xBEEF with sel = 4'b0001 over 0x0000 → OPA reads 0x00EF. A non-matching address gives no ack.
- With KSA_ACCUM_EN:
  - Accumulate on, OPA = 0, OPB = 0x4000, four starts → OPA = 0x0000.
  - Overflow sticky = 1 after the 4th capture.
  - RESULT = 0x0001_0000.
